// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/mem_arbiter_wait_ctr.sv
// Saturating count of consecutive contested cycles that fetch has lost;
// force_fetch asserts once the count reaches FETCH_MAX_WAIT.
module mem_arbiter_wait_ctr #(
  parameter int unsigned FETCH_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic contested_loss,
  input  logic clear,
  output logic force_fetch
);

  localparam logic [3:0] MAX_WAIT = 4'(FETCH_MAX_WAIT);

  logic [3:0] wait_cnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= MAX_WAIT) ? MAX_WAIT : cnt + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wait_cnt <= 4'd0;
    end else if (contested_loss) begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  assign force_fetch = (wait_cnt == MAX_WAIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Optional MEM_ARBITER_STORE_OVERLAP_EN lets a word store share a cycle with a fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned FETCH_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [2:0]  d_req_funct3,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  logic   force_fetch;
  logic   overlap_ok;
  logic   fetch_grant;
  logic   load_grant;
  logic   store_grant;
  logic   contested_loss;
  logic   wait_clear;
  owner_t owner;
  owner_t owner_next;

`ifdef MEM_ARBITER_STORE_OVERLAP_EN
  // A word store and a fetch both drive funct3 = 010, so they can share the port.
  assign overlap_ok = if_req_valid && d_req_valid && d_req_we &&
                      (d_req_funct3 == FUNCT3_WORD);
`else
  assign overlap_ok = 1'b0;
`endif

  always_comb begin
    fetch_grant = 1'b0;
    load_grant  = 1'b0;
    store_grant = 1'b0;
    if (rst_n) begin
      if (overlap_ok) begin
        // Same word: let the store land first so the fetch sees new data.
        store_grant = 1'b1;
        fetch_grant = !same_word(d_req_addr, if_req_addr);
      end else if (if_req_valid && (!d_req_valid || force_fetch)) begin
        fetch_grant = 1'b1;
      end else if (d_req_valid) begin
        load_grant  = !d_req_we;
        store_grant = d_req_we;
      end
    end
  end

  assign if_req_ready   = fetch_grant;
  assign d_req_ready    = load_grant || store_grant;
  assign contested_loss = if_req_valid && d_req_valid && !fetch_grant;
  assign wait_clear     = fetch_grant || !if_req_valid;

  mem_arbiter_wait_ctr #(
    .FETCH_MAX_WAIT (FETCH_MAX_WAIT)
  ) u_wait_ctr (
    .clk            (clk),
    .rst_n          (rst_n),
    .contested_loss (contested_loss),
    .clear          (wait_clear),
    .force_fetch    (force_fetch)
  );

  always_comb begin
    mem_write_mem     = 1'b0;
    mem_funct3        = FUNCT3_WORD;
    mem_write_address = 32'd0;
    mem_write_data    = 32'd0;
    mem_read_address  = 32'd0;
    owner_next        = OWN_NONE;
    if (store_grant) begin
      mem_write_mem     = 1'b1;
      mem_funct3        = d_req_funct3;
      mem_write_address = d_req_addr;
      mem_write_data    = d_req_wdata;
    end
    if (fetch_grant) begin
      mem_read_address = if_req_addr;
      owner_next       = OWN_IF;
    end else if (load_grant) begin
      mem_read_address = d_req_addr;
      mem_funct3       = d_req_funct3;
      owner_next       = OWN_D;
    end
  end

  // Grant cycle -> response cycle: owner steers the returning read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  assign if_rsp_valid = (owner == OWN_IF);
  assign d_rsp_valid  = (owner == OWN_D);
  assign if_rsp_data  = mem_read_data;
  assign d_rsp_data   = mem_read_data;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer that shares the single-transaction RV32I `memory` port between the instruction-fetch unit and the load/store unit. It sits between the core and `memory`:
- issues at most one read per cycle, plus at most one write when the configuration below allows it;
- tracks `memory`'s fixed 1-cycle read latency and steers each response to its owner;
- guarantees fetch forward progress with a bounded-wait counter.

## Interface
- `FETCH_MAX_WAIT`, default 4: consecutive contested cycles fetch may lose before it is forced to win (range 1–15).
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `if_req_valid` in 1: fetch read request.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_req_addr` in 32: fetch byte address.
- `if_rsp_valid` out 1: fetch read data valid.
- `if_rsp_data` out 32: fetch read data.
- `d_req_valid` in 1: data request.
- `d_req_ready` out 1: data request accepted this cycle.
- `d_req_we` in 1: 1 = store, 0 = load.
- `d_req_funct3` in 3: access size/sign (RV32I funct3).
- `d_req_addr` in 32: data byte address.
- `d_req_wdata` in 32: store data, right-aligned.
- `d_rsp_valid` out 1: load data valid.
- `d_rsp_data` out 32: load data.
- `mem_write_mem` out 1: to `memory.write_mem`.
- `mem_funct3` out 3: to `memory.funct3`.
- `mem_write_address` out 32: to `memory.write_address`.
- `mem_write_data` out 32: to `memory.write_data`.
- `mem_read_address` out 32: to `memory.read_address`.
- `mem_read_data` in 32: from `memory.read_data`.

## Operation
- A request transfers when valid && ready. Ready is combinational from the valids and the arbiter state. A requester holds its request stable while valid && !ready.
- `memory` has one shared `funct3`, so by default each cycle grants exactly one transaction: a fetch read, a data load or a data store.
- **Uncontested:** if only one requester is valid, it is granted.
- **Contested (both valid):** data wins, unless `wait_cnt == FETCH_MAX_WAIT`, in which case fetch wins.
- **`wait_cnt`:**
  - increments on every contested cycle that fetch loses, saturating at `FETCH_MAX_WAIT`;
  - clears on a fetch grant or when `if_req_valid` is low.
- **Fetch grant:** `mem_read_address = if_req_addr`, `mem_funct3 = 3'b010`, `mem_write_mem = 0`, `owner <= OWN_IF`.
- **Load grant:** `mem_read_address = d_req_addr`, `mem_funct3 = d_req_funct3`, `mem_write_mem = 0`, `owner <= OWN_D`.
- **Store grant:** `mem_write_mem = 1`, write address/data/funct3 taken from the d_req signals, `owner <= OWN_NONE`. Stores produce no response.
- **No grant:** `mem_write_mem = 0`, `mem_funct3 = 3'b010`, both addresses 0, `owner <= OWN_NONE`.
- **Responses:**
  - `if_rsp_valid = (owner == OWN_IF)` and `d_rsp_valid = (owner == OWN_D)`.
  - Both rsp_data outputs pass `mem_read_data` through combinationally.
  - There is no response backpressure; requesters must sink responses.

## Timing
- Request granted in cycle N → response valid in cycle N+1. This is a fixed single-cycle latency, with at most one read in flight.
- Back-to-back grants sustain one read per cycle. Owners may alternate every cycle.
- **Reset values:**
  - `owner = OWN_NONE`, `wait_cnt = 0`.
  - `if_rsp_valid = d_rsp_valid = 0`, `if_req_ready = d_req_ready = 0`, `mem_write_mem = 0`.
- **Reset mid-operation:** rst_n low at edge N drops any read granted in N; no rsp_valid in N+1. Readies are 0 while rst_n is low.
- **Starvation bound:** a continuously valid fetch is granted within `FETCH_MAX_WAIT`+1 cycles, even under continuous data traffic.
- Stores to peripheral addresses (e.g. 0xFFFFFFFC) are arbitrated identically; the arbiter does no address decode.

## Configuration
- `MEM_ARBITER_STORE_OVERLAP_EN`:
  - **Defined:** a data store with `d_req_funct3 == 3'b010` may be granted in the same cycle as a fetch read, since both use `funct3` 010. Both readies are high and `owner <= OWN_IF`.
    - Exception: if `d_req_addr[31:2] == if_req_addr[31:2]`, only the store is granted and fetch waits one cycle, so it reads the new data.
    - Overlapped grants count as fetch grants for `wait_cnt`.
  - **Undefined:** strictly one transaction per cycle, as described in Operation.

## Structure
- Package `mem_arbiter_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t`;
  - localparam `FUNCT3_WORD = 3'b010`.
- Sub-module `mem_arbiter_wait_ctr`: the saturating bounded-wait counter.
  - Inputs: `clk`, `rst_n`, `contested_loss`, `clear`.
  - Output: `force_fetch`.
- Top level holds the grant logic, the `owner` register and the output muxing.

## Test plan
- Fetch-only stream, addresses 0x0, 0x4, 0x8 (memory preloaded) → `if_rsp_valid` in each following cycle with the preloaded words; `d_rsp_valid` stays 0.
- Load 0x10 with funct3 `3'b100`, word 0x000000F0 → `d_rsp_data = 0x000000F0` one cycle later. Same word with funct3 `3'b000` → `0xFFFFFFF0`.
- Both valid continuously, `FETCH_MAX_WAIT = 4` → data granted 4 cycles, fetch granted on the 5th; the pattern repeats.
- Store 0x12345678 to 0x20, then fetch 0x20 in the next cycle → `if_rsp_data = 0x12345678`. Store to 0xFFFFFFFC → `mem_write_mem` = 1 for one cycle with no response.
- rst_n low in the cycle a load is granted → no `d_rsp_valid` in the next cycle; readies 0 during reset; `wait_cnt` restarts at 0.
- With `MEM_ARBITER_STORE_OVERLAP_EN`:
  - word store 0x40 and fetch 0x44 → both accepted in the same cycle;
  - word store 0x40 and fetch 0x40 → fetch accepted one cycle later and returns the stored data.
